// File: rtl/regfile_dump.sv
// regfile_dump
//   Walks a register file through its debug port (address + debug clock)
//   and streams every selected 32-bit word out as four bytes on a
//   valid/ready byte interface.
//
// Parameters
//   MSB_FIRST   1: byte 0 of each word is bits 31:24; 0: byte 0 is bits 7:0
//
// Ports
//   clock       sole clock, all state changes on its rising edge
//   reset       asynchronous active-low reset
//   start       single-cycle request to begin a dump (honoured only in IDLE)
//   abort       synchronous cancel of an in-progress dump
//   first_addr  first register index to dump
//   last_addr   last register index to dump (inclusive, wraps 31->0)
//   dbg_addr    register file debug read address
//   dbg_clock   register file debug clock (register file samples on rise)
//   dbg_data    register file debug read data
//   byte_data   outbound byte
//   byte_valid  byte_data is valid
//   byte_ready  sink accepts byte_data
//   busy        dump in progress (ADDR..SEND)
//   done        one-cycle pulse after the final byte has been accepted
module regfile_dump #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  first_addr,
  input  logic [4:0]  last_addr,
  output logic [4:0]  dbg_addr,
  output logic        dbg_clock,
  input  logic [31:0] dbg_data,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    STROBE  = 3'd2,
    CAPTURE = 3'd3,
    SEND    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cur_addr_q, cur_addr_d;
  logic [4:0]  end_addr_q, end_addr_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;

  logic [4:0]  dbg_addr_q, dbg_addr_d;
  logic        dbg_clock_q, dbg_clock_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Byte lane selection for a given position within the word.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [1:0] lane;
    logic [7:0] b;
    lane = MSB_FIRST ? (2'd3 - idx) : idx;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    end_addr_d   = end_addr_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    dbg_addr_d   = dbg_addr_q;
    dbg_clock_d  = 1'b0;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          cur_addr_d = first_addr;
          end_addr_d = last_addr;
          state_d    = ADDR;
        end
      end
      ADDR:    state_d = STROBE;
      STROBE:  state_d = CAPTURE;
      CAPTURE: begin
        // register file output has settled since the debug clock rose
        word_d     = dbg_data;
        byte_idx_d = 2'd0;
        state_d    = SEND;
      end
      SEND: begin
        if (byte_valid_q && byte_ready) begin
          if (byte_idx_q == 2'd3) begin
            if (cur_addr_q == end_addr_q) begin
              state_d = DONE;
            end else begin
              cur_addr_d = cur_addr_q + 5'd1;  // 5-bit wrap 31->0
              state_d    = ADDR;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end

    // Outputs are registered from the state being entered so that they
    // line up with that state's cycle.
    if (state_d == ADDR) begin
      dbg_addr_d = cur_addr_d;
    end
    dbg_clock_d  = (state_d == STROBE);
    byte_valid_d = (state_d == SEND);
    busy_d       = (state_d == ADDR) || (state_d == STROBE) ||
                   (state_d == CAPTURE) || (state_d == SEND);
    done_d       = (state_d == DONE);
    // word_d/byte_idx_d are unchanged during a stall, so the byte holds.
    if (state_d == SEND) begin
      byte_data_d = pick_byte(word_d, byte_idx_d);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cur_addr_q   <= 5'd0;
      end_addr_q   <= 5'd0;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'd0;
      dbg_addr_q   <= 5'd0;
      dbg_clock_q  <= 1'b0;
      byte_data_q  <= 8'd0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      end_addr_q   <= end_addr_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      dbg_addr_q   <= dbg_addr_d;
      dbg_clock_q  <= dbg_clock_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign dbg_addr   = dbg_addr_q;
  assign dbg_clock  = dbg_clock_q;
  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Testbench for regfile_dump: one instance per byte order, driven by the
// same stimulus, each attached to its own register file model.
module tb_regfile_dump;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic        byte_ready;

  logic [4:0]  dbg_addr0, dbg_addr1;
  logic        dbg_clock0, dbg_clock1;
  logic [31:0] dbg_data0, dbg_data1;
  logic [7:0]  byte_data0, byte_data1;
  logic        byte_valid0, byte_valid1;
  logic        busy0, busy1;
  logic        done0, done1;

  regfile_dump #(.MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .dbg_addr(dbg_addr0), .dbg_clock(dbg_clock0), .dbg_data(dbg_data0),
    .byte_data(byte_data0), .byte_valid(byte_valid0), .byte_ready(byte_ready),
    .busy(busy0), .done(done0)
  );

  regfile_dump #(.MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .dbg_addr(dbg_addr1), .dbg_clock(dbg_clock1), .dbg_data(dbg_data1),
    .byte_data(byte_data1), .byte_valid(byte_valid1), .byte_ready(byte_ready),
    .busy(busy1), .done(done1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model: read port sampled on the rising debug clock.
  logic [31:0] rf [32];
  initial begin
    dbg_data0 = 32'd0;
    dbg_data1 = 32'd0;
  end
  always @(posedge dbg_clock0) dbg_data0 <= rf[dbg_addr0];
  always @(posedge dbg_clock1) dbg_data1 <= rf[dbg_addr1];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit rand_ready = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         stall_pend[2];
  logic [7:0] stall_data[2];
  int         done_cnt[2];
  int         done_cyc[2];
  int         popped[2];
  int         accept_cyc;
  int         done_base;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    byte_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [7:0] d, input logic dn);
    logic [7:0] e;
    if (v) begin
      if (stall_pend[k]) chk($sformatf("stall_stable%0d", k), {24'd0, d}, {24'd0, stall_data[k]});
      if (byte_ready) begin
        n_checks++;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          n_err++;
          $display("FAIL unexpected_byte%0d: got %0h expected none", k, d);
        end else begin
          n_checks--;
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("byte%0d", k), {24'd0, d}, {24'd0, e});
        end
        popped[k]++;
        stall_pend[k] = 1'b0;
      end else begin
        stall_pend[k] = 1'b1;
        stall_data[k] = d;
      end
    end else begin
      stall_pend[k] = 1'b0;
    end
    if (dn) begin
      done_cnt[k]++;
      done_cyc[k] = cyc;
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clock);
    mon(0, byte_valid0, byte_data0, done0);
    mon(1, byte_valid1, byte_data1, done1);
  end

  // Reference model: the sequence of bytes a dump from f to l must produce.
  task automatic issue(input logic [4:0] f, input logic [4:0] l);
    int a;
    logic [31:0] w;
    a = f;
    for (int n = 0; n < 32; n++) begin
      w = rf[a];
      for (int b = 0; b < 4; b++) begin
        q0.push_back(8'((w >> (8 * (3 - b))) & 32'hff));
        q1.push_back(8'((w >> (8 * b)) & 32'hff));
      end
      if (a == int'(l)) break;
      a = (a + 1) % 32;
    end
    done_base  = done_cnt[0];
    start      = 1'b1;
    first_addr = f;
    last_addr  = l;
    @(posedge clock);
    #1;
    accept_cyc = cyc;
    start      = 1'b0;
    first_addr = 5'($urandom);
    last_addr  = 5'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit poke, input string tag);
    int i;
    int b1;
    b1 = done_cnt[1];
    for (i = 0; i < budget; i++) begin
      @(negedge clock);
      #1;
      if (done_cnt[0] > done_base) break;
    end
    if (i >= budget) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout_%s: got no done expected done within %0d cycles", tag, budget);
    end
    chk("busy_in_done", {31'd0, busy0}, 32'd0);
    if (poke) begin
      start      = 1'b1;
      first_addr = 5'd0;
      last_addr  = 5'd0;
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    repeat (3) @(negedge clock);
    #1;
    chk($sformatf("done_count0_%s", tag), done_cnt[0] - done_base, 1);
    chk($sformatf("done_count1_%s", tag), done_cnt[1] - b1, 1);
    chk($sformatf("q0_empty_%s", tag), q0.size(), 0);
    chk($sformatf("q1_empty_%s", tag), q1.size(), 0);
    chk($sformatf("busy_after_%s", tag), {31'd0, busy0 | busy1}, 32'd0);
    $display("dump %s: done after %0d cycles, %0d checks so far", tag, done_cyc[0] - accept_cyc, n_checks);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_dbg_addr"},   {27'd0, dbg_addr0 | dbg_addr1}, 32'd0);
    chk({tag, "_dbg_clock"},  {31'd0, dbg_clock0 | dbg_clock1}, 32'd0);
    chk({tag, "_byte_data"},  {24'd0, byte_data0 | byte_data1}, 32'd0);
    chk({tag, "_byte_valid"}, {31'd0, byte_valid0 | byte_valid1}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy0 | busy1}, 32'd0);
    chk({tag, "_done"},       {31'd0, done0 | done1}, 32'd0);
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    stall_pend[0] = 1'b0;
    stall_pend[1] = 1'b0;
  endtask

  initial begin
    int i;
    bit seen_valid;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    first_addr = 5'd0; last_addr = 5'd0;
    for (int r = 0; r < 32; r++) rf[r] = 32'd0;
    rf[29] = 32'h7fff_fffc;
    for (int k = 0; k < 2; k++) begin
      stall_pend[k] = 1'b0; stall_data[k] = 8'd0;
      done_cnt[k] = 0; done_cyc[k] = 0; popped[k] = 0;
    end

    repeat (3) @(posedge clock);
    #1;
    chk_reset_outs("por");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Full sweep, freshly reset register file, ready always high.
    issue(5'd0, 5'd31);
    wait_done(400, 1'b0, "full");
    chk("full_latency", done_cyc[0] - accept_cyc, 224);

    // Single word; a start in the DONE cycle must be ignored.
    issue(5'd29, 5'd29);
    wait_done(50, 1'b1, "single29");

    // Wrap-around dump, with a spurious start mid-dump.
    rf[30] = 32'h1122_3344; rf[31] = 32'h5566_7788;
    rf[0]  = 32'h0000_0000; rf[1]  = 32'haabb_ccdd;
    issue(5'd30, 5'd1);
    repeat (6) @(posedge clock);
    #1;
    start = 1'b1; first_addr = 5'd7; last_addr = 5'd9;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(100, 1'b0, "wrap");

    // Back-pressure on a single word.
    rf[5] = 32'hdead_beef;
    rand_ready = 1'b1;
    issue(5'd5, 5'd5);
    wait_done(200, 1'b0, "stall5");

    // Randomised contents and ranges under back-pressure.
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 32; r++) rf[r] = $urandom;
      issue(5'($urandom), 5'($urandom));
      wait_done(3000, 1'b0, $sformatf("rand%0d", t));
    end
    rand_ready = 1'b0;

    // Asynchronous reset in the SEND of the second word.
    issue(5'd0, 5'd3);
    for (i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      if (popped[0] >= 5) break;
    end
    chk("reach_word2", {31'd0, (i < 100)}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk_reset_outs("midreset");
    clear_model();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen_valid = 1'b0;
    repeat (20) begin
      @(negedge clock);
      #1;
      seen_valid = seen_valid | byte_valid0 | byte_valid1 | busy0 | busy1;
    end
    chk("idle_after_reset", {31'd0, seen_valid}, 32'd0);

    // Abort during STROBE, then a clean dump of reg 2.
    issue(5'd10, 5'd12);
    for (i = 0; i < 20; i++) begin
      if (dbg_clock0) break;
      @(negedge clock);
      #1;
    end
    chk("reach_strobe", {31'd0, dbg_clock0}, 32'd1);
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    chk("abort_busy",  {31'd0, busy0 | busy1}, 32'd0);
    chk("abort_valid", {31'd0, byte_valid0 | byte_valid1}, 32'd0);
    chk("abort_dbgclk", {31'd0, dbg_clock0 | dbg_clock1}, 32'd0);
    clear_model();
    repeat (10) @(negedge clock);
    #1;
    chk("abort_no_done", done_cnt[0] - done_base, 0);
    rf[2] = 32'h0bad_f00d;
    issue(5'd2, 5'd2);
    wait_done(50, 1'b0, "after_abort");

    // abort beats start in IDLE.
    start = 1'b1; abort = 1'b1; first_addr = 5'd4; last_addr = 5'd4;
    @(posedge clock);
    #1;
    start = 1'b0; abort = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    chk("idle_abort_over_start", {31'd0, busy0 | busy1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
